pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage in-order pipeline. It drives the freeze/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It handles three cases: load-use hazards, EX-stage control-flow redirects, and instruction/data memory wait states. It also keeps performance counters and a memory-timeout watchdog.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline stall/flush controller:
//   reg_idx_t - architectural register index (x0..x31)
//   REG_ZERO  - hard-wired zero register; it never creates a dependency
//   state_t   - controller FSM states
//   ctrl_t    - bundle of pipeline-register and PC control strobes
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_sel_redirect;
    logic ifid_freeze;
    logic ifid_flush;
    logic idex_freeze;
    logic idex_flush;
    logic exmem_freeze;
    logic memwb_flush;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard-status inputs coming from the pipeline stages and the
// stall/flush controls plus status going back to them.
//   master : pipeline side (drives hazard status, receives controls)
//   slave  : controller side (receives hazard status, drives controls)
// Hazard status : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2, ex_rd/ex_is_load/
//                 ex_reg_write/ex_redirect, imem_ready, dmem_req/dmem_ready
// Controls      : pc_we, pc_sel_redirect, ifid_freeze/flush, idex_freeze/
//                 flush, exmem_freeze, memwb_flush
// Status        : stall_cycles, redirect_count (CNT_W), mem_timeout_err
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  reg_idx_t           id_rs1;
  reg_idx_t           id_rs2;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  reg_idx_t           ex_rd;
  logic               ex_is_load;
  logic               ex_reg_write;
  logic               ex_redirect;
  logic               imem_ready;
  logic               dmem_req;
  logic               dmem_ready;

  logic               pc_we;
  logic               pc_sel_redirect;
  logic               ifid_freeze;
  logic               ifid_flush;
  logic               idex_freeze;
  logic               idex_flush;
  logic               exmem_freeze;
  logic               memwb_flush;
  logic [CNT_W-1:0]   stall_cycles;
  logic [CNT_W-1:0]   redirect_count;
  logic               mem_timeout_err;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_is_load, ex_reg_write, ex_redirect,
    output imem_ready, dmem_req, dmem_ready,
    input  pc_we, pc_sel_redirect, ifid_freeze, ifid_flush,
    input  idex_freeze, idex_flush, exmem_freeze, memwb_flush,
    input  stall_cycles, redirect_count, mem_timeout_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_is_load, ex_reg_write, ex_redirect,
    input  imem_ready, dmem_req, dmem_ready,
    output pc_we, pc_sel_redirect, ifid_freeze, ifid_flush,
    output idex_freeze, idex_flush, exmem_freeze, memwb_flush,
    output stall_cycles, redirect_count, mem_timeout_err
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags the case where the load in
// EX writes a register that the instruction in ID actually reads.
//   i_id_rs1/i_id_rs2         source registers of the ID instruction
//   i_id_uses_rs1/i_id_uses_rs2 the ID instruction really reads that source
//   i_ex_rd                   destination of the EX instruction
//   i_ex_is_load/i_ex_reg_write EX instruction is a register-writing load
//   o_load_use                one-cycle bubble required
// ----------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_idx_t i_id_rs1,
  input  reg_idx_t i_id_rs2,
  input  logic     i_id_uses_rs1,
  input  logic     i_id_uses_rs2,
  input  reg_idx_t i_ex_rd,
  input  logic     i_ex_is_load,
  input  logic     i_ex_reg_write,
  output logic     o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_ex_writes;

  assign w_rs1_hit   = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit   = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is never written, so a load targeting it cannot create a dependency
  assign w_ex_writes = i_ex_is_load && i_ex_reg_write && (i_ex_rd != REG_ZERO);
  assign o_load_use  = w_ex_writes && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage in-order pipeline.
// Priority (highest first): dmem stall > EX redirect > post-redirect squash
// > load-use > imem wait > normal flow. Controls are combinational from the
// registered state and the current inputs; state and counters are registered.
//   clk  - clock, rising edge
//   rstn - synchronous active-low reset; all controls forced low while low
//   bus  - slave side of pipeline_hazard_ctrl_if (hazard status in, controls
//          and performance/watchdog status out)
// Parameters:
//   REDIRECT_FLUSH_CYCLES (1..7) cycles IF/ID is flushed after a redirect
//   MEM_TIMEOUT (2..65535) consecutive dmem-wait cycles that trip watchdog
//   CNT_W performance counter width
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT           = 256,
  parameter int unsigned CNT_W                 = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [2:0]  FLUSH_RELOAD = 3'(REDIRECT_FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT      = 16'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_flush_cnt;
  logic [2:0]       w_flush_cnt_nxt;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_redirect_count;
  logic             r_mem_timeout_err;

  ctrl_t            w_ctrl;
  ctrl_t            w_ctrl_out;
  logic             w_load_use;
  logic             w_dmem_stall;
  logic             w_in_flush;
  logic             w_redirect_accept;

  hazard_detect u_hazard_detect (
    .i_id_rs1       (bus.id_rs1),
    .i_id_rs2       (bus.id_rs2),
    .i_id_uses_rs1  (bus.id_uses_rs1),
    .i_id_uses_rs2  (bus.id_uses_rs2),
    .i_ex_rd        (bus.ex_rd),
    .i_ex_is_load   (bus.ex_is_load),
    .i_ex_reg_write (bus.ex_reg_write),
    .o_load_use     (w_load_use)
  );

  assign w_dmem_stall = bus.dmem_req && !bus.dmem_ready;

  // A squash sequence paused by a dmem stall resumes on the cycle the stall
  // releases, so MEM_WAIT with a live flush count still counts as flushing.
  assign w_in_flush = (r_state == FLUSH) ||
                      ((r_state == MEM_WAIT) && (r_flush_cnt != 3'd0));

  always_comb begin
    w_ctrl            = '0;
    w_state_nxt       = r_state;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_redirect_accept = 1'b0;

    if (w_dmem_stall) begin
      // Freeze everything up to EX/MEM; MEM/WB gets a bubble. EX inputs are
      // frozen too, so any redirect/load-use is simply seen again later.
      w_ctrl.ifid_freeze  = 1'b1;
      w_ctrl.idex_freeze  = 1'b1;
      w_ctrl.exmem_freeze = 1'b1;
      w_ctrl.memwb_flush  = 1'b1;
      w_state_nxt         = MEM_WAIT;
    end else if (bus.ex_redirect) begin
      w_ctrl.pc_we           = 1'b1;
      w_ctrl.pc_sel_redirect = 1'b1;
      w_ctrl.ifid_flush      = 1'b1;
      w_ctrl.idex_flush      = 1'b1;
      w_redirect_accept      = 1'b1;
      w_flush_cnt_nxt        = FLUSH_RELOAD;
      w_state_nxt            = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
    end else if (w_in_flush) begin
      w_ctrl.pc_we      = 1'b1;
      w_ctrl.ifid_flush = 1'b1;
      if (r_flush_cnt == 3'd1) begin
        w_flush_cnt_nxt = 3'd0;
        w_state_nxt     = RUN;
      end else begin
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        w_state_nxt     = FLUSH;
      end
    end else begin
      w_state_nxt = RUN;
      if (w_load_use) begin
        w_ctrl.ifid_freeze = 1'b1;
        w_ctrl.idex_flush  = 1'b1;
      end else if (!bus.imem_ready) begin
        w_ctrl.ifid_flush = 1'b1;
      end else begin
        w_ctrl.pc_we = 1'b1;
      end
    end
  end

  assign w_ctrl_out = rstn ? w_ctrl : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt        <= '0;
      r_mem_timeout_err <= 1'b0;
    end else if (w_dmem_stall) begin
      if (r_wait_cnt != TIMEOUT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      // Sets on the same edge the count reaches the limit
      if (r_wait_cnt >= TIMEOUT - 16'd1) begin
        r_mem_timeout_err <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      if (!w_ctrl.pc_we) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_redirect_accept) begin
        r_redirect_count <= r_redirect_count + 1'b1;
      end
    end
  end

  assign bus.pc_we           = w_ctrl_out.pc_we;
  assign bus.pc_sel_redirect = w_ctrl_out.pc_sel_redirect;
  assign bus.ifid_freeze     = w_ctrl_out.ifid_freeze;
  assign bus.ifid_flush      = w_ctrl_out.ifid_flush;
  assign bus.idex_freeze     = w_ctrl_out.idex_freeze;
  assign bus.idex_flush      = w_ctrl_out.idex_flush;
  assign bus.exmem_freeze    = w_ctrl_out.exmem_freeze;
  assign bus.memwb_flush     = w_ctrl_out.memwb_flush;
  assign bus.stall_cycles    = r_stall_cycles;
  assign bus.redirect_count  = r_redirect_count;
  assign bus.mem_timeout_err = r_mem_timeout_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed vectors with hand-written expected control words, checked by a
// scoreboard queue drained by a negedge monitor. Control word bit order:
// {pc_we, pc_sel_redirect, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
//  exmem_freeze, memwb_flush}.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RFC   = 3;
  localparam int unsigned MT    = 8;
  localparam int unsigned CNT_W = 32;

  localparam logic [7:0] C_RST  = 8'h00;
  localparam logic [7:0] C_NORM = 8'h80;
  localparam logic [7:0] C_LU   = 8'h24;
  localparam logic [7:0] C_RDR  = 8'hD4;
  localparam logic [7:0] C_FL   = 8'h90;
  localparam logic [7:0] C_DMS  = 8'h2B;
  localparam logic [7:0] C_IMW  = 8'h10;

  typedef struct {
    logic       rstn;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, rw, redir, imr, dreq, drdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] ctrl;
    logic       chk;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] redir;
    logic       err;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   vec_idx;

  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_redir;
  int unsigned      m_wait;
  logic             m_err;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .REDIRECT_FLUSH_CYCLES(RFC),
    .MEM_TIMEOUT(MT),
    .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic vec_t nv(input logic [7:0] exp);
    vec_t v;
    v.rstn = 1'b1; v.rs1 = '0; v.rs2 = '0; v.rd = '0;
    v.u1 = 1'b0; v.u2 = 1'b0; v.ld = 1'b0; v.rw = 1'b0; v.redir = 1'b0;
    v.imr = 1'b1; v.dreq = 1'b0; v.drdy = 1'b1; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rstn             = v.rstn;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_uses_rs1  = v.u1;
    bus.id_uses_rs2  = v.u2;
    bus.ex_rd        = v.rd;
    bus.ex_is_load   = v.ld;
    bus.ex_reg_write = v.rw;
    bus.ex_redirect  = v.redir;
    bus.imem_ready   = v.imr;
    bus.dmem_req     = v.dreq;
    bus.dmem_ready   = v.drdy;
  endtask

  // Apply one vector for one cycle, queue its expectation, advance the
  // expected counters by what the edge closing this cycle should do.
  task automatic run(input vec_t v);
    exp_t e;
    drive(v);
    e.idx   = vec_idx;
    e.ctrl  = v.exp;
    e.chk   = v.rstn;
    e.stall = m_stall;
    e.redir = m_redir;
    e.err   = m_err;
    sb.push_back(e);
    vec_idx++;
    if (!v.rstn) begin
      m_stall = '0; m_redir = '0; m_wait = 0; m_err = 1'b0;
    end else begin
      if (!v.exp[7]) m_stall++;
      if (v.exp[6])  m_redir++;
      if (v.dreq && !v.drdy) begin
        if (m_wait < MT) m_wait++;
        if (m_wait == MT) m_err = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] got;
    got = {bus.pc_we, bus.pc_sel_redirect, bus.ifid_freeze, bus.ifid_flush,
           bus.idex_freeze, bus.idex_flush, bus.exmem_freeze, bus.memwb_flush};
    n_cmp++;
    if (((bus.ifid_freeze & bus.ifid_flush) | (bus.idex_freeze & bus.idex_flush)) !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap t=%0t ctrl got %b required no freeze+flush pair", $time, got);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (got !== e.ctrl) begin
        n_bad++;
        $display("FAIL ctrl vec%0d got %b required %b", e.idx, got, e.ctrl);
      end
      if (e.chk) begin
        n_cmp += 3;
        if (bus.stall_cycles !== e.stall) begin
          n_bad++;
          $display("FAIL stall_cycles vec%0d got %0d required %0d", e.idx, bus.stall_cycles, e.stall);
        end
        if (bus.redirect_count !== e.redir) begin
          n_bad++;
          $display("FAIL redirect_count vec%0d got %0d required %0d", e.idx, bus.redirect_count, e.redir);
        end
        if (bus.mem_timeout_err !== e.err) begin
          n_bad++;
          $display("FAIL mem_timeout_err vec%0d got %b required %b", e.idx, bus.mem_timeout_err, e.err);
        end
      end
    end
  end

  initial begin
    vec_t v;
    n_cmp = 0; n_bad = 0; vec_idx = 0;
    m_stall = '0; m_redir = '0; m_wait = 0; m_err = 1'b0;

    // Reset, then plain flow
    v = nv(C_RST); v.rstn = 1'b0; run(v); run(v);
    run(nv(C_NORM)); run(nv(C_NORM));

    // Load-use on rs1, then the load has moved on
    v = nv(C_LU); v.ld = 1; v.rw = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.u1 = 1; run(v);
    run(nv(C_NORM));
    // Load targeting x0 never stalls
    v.rd = 5'd0; v.rs1 = 5'd0; v.exp = C_NORM; run(v);
    // Load-use on rs2; unused rs2 and non-load do not stall
    v = nv(C_LU); v.ld = 1; v.rw = 1; v.rd = 5'd7; v.rs2 = 5'd7; v.u2 = 1; run(v);
    v.u2 = 0; v.exp = C_NORM; run(v);
    v.u2 = 1; v.ld = 0; run(v);

    // Redirect pulse: redirect cycle, two squash cycles, normal
    v = nv(C_RDR); v.redir = 1; run(v);
    run(nv(C_FL)); run(nv(C_FL)); run(nv(C_NORM));

    // dmem stall for 4 cycles with redirect held; redirect taken on 5th
    v = nv(C_DMS); v.redir = 1; v.dreq = 1; v.drdy = 0;
    for (int i = 0; i < 4; i++) run(v);
    v.drdy = 1; v.exp = C_RDR; run(v);
    run(nv(C_FL)); run(nv(C_FL)); run(nv(C_NORM));

    // Second redirect during squash reloads the count
    v = nv(C_RDR); v.redir = 1; run(v);
    run(nv(C_FL));
    run(v);
    run(nv(C_FL)); run(nv(C_FL)); run(nv(C_NORM));

    // dmem stall pauses squash; it resumes for the last cycle
    v = nv(C_RDR); v.redir = 1; run(v);
    run(nv(C_FL));
    v = nv(C_DMS); v.dreq = 1; v.drdy = 0; run(v); run(v);
    run(nv(C_FL)); run(nv(C_NORM));

    // Squash outranks load-use; load-use still pending afterwards
    v = nv(C_RDR); v.redir = 1; run(v);
    v = nv(C_FL); v.ld = 1; v.rw = 1; v.rd = 5'd9; v.rs1 = 5'd9; v.u1 = 1; run(v);
    run(v);
    v.exp = C_LU; run(v);
    // Load-use outranks imem wait; imem wait alone
    v.imr = 0; run(v);
    v = nv(C_IMW); v.imr = 0; run(v);
    run(nv(C_NORM));

    // Watchdog: one short of the limit, then exactly the limit
    v = nv(C_DMS); v.dreq = 1; v.drdy = 0;
    for (int i = 0; i < MT - 1; i++) run(v);
    run(nv(C_NORM));
    for (int i = 0; i < MT; i++) run(v);
    run(nv(C_NORM)); run(nv(C_NORM)); run(nv(C_NORM));

    // Reset while squashing
    v = nv(C_RDR); v.redir = 1; run(v);
    run(nv(C_FL));
    v = nv(C_RST); v.rstn = 1'b0; v.redir = 1; v.dreq = 1; v.drdy = 0; run(v); run(v);
    run(nv(C_NORM)); run(nv(C_NORM));

    // Random traffic: only the freeze/flush exclusivity check applies
    for (int i = 0; i < 300; i++) begin
      v = nv(C_NORM);
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom); v.ld = 1'($urandom);
      v.rw = 1'($urandom); v.redir = ($urandom_range(0, 7) == 0);
      v.imr = ($urandom_range(0, 3) != 0); v.dreq = 1'($urandom);
      v.drdy = ($urandom_range(0, 2) != 0);
      drive(v);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left %0d required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
